// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle fetch/decode/execute/writeback sequencer.
// It owns the program counter and the instruction register, and runs the
// instruction-fetch request/ack handshake.
// It resolves JMP, BRZ and HALT locally, strobes the ALU and the register
// file for one cycle each, and counts retired instructions for debug.
//
// Fetch handshake: mem_req is high for every cycle spent in FETCH.
// mem_addr (= pc) is held stable for as long as mem_req is high.
// A transfer completes in the cycle where mem_req and mem_ack are both high.
// mem_rdata is captured on that same edge, and mem_req is low on the cycle
// after it.
module cpu_seq_ctrl #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    input  logic              zero_flag,
    output logic [15:0]       ir,
    output logic [ADDR_W-1:0] pc,
    output logic              alu_en,
    output logic              wb_en,
    output logic              halted,
    output logic [2:0]        state,
    output logic [15:0]       retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_BRZ  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [15:0]         r_ir;
    logic [15:0]         r_retired;

    logic [3:0]          w_opcode;
    logic                w_is_nop;
    logic                w_is_jmp;
    logic                w_is_brz;
    logic                w_is_halt;
    logic                w_is_alu;
    logic [ADDR_W-1:0]   w_target;
    logic                w_redirect;
    logic                w_fetch_done;
    logic                w_retire;

    // Instruction decode from the latched IR; only meaningful in DECODE.
    assign w_opcode  = r_ir[15:12];
    assign w_is_nop  = (w_opcode == OP_NOP);
    assign w_is_jmp  = (w_opcode == OP_JMP);
    assign w_is_brz  = (w_opcode == OP_BRZ);
    assign w_is_halt = (w_opcode == OP_HALT);
    assign w_is_alu  = !(w_is_nop || w_is_jmp || w_is_brz || w_is_halt);

    // Jump/branch target is the 12-bit immediate, zero-extended.
    assign w_target   = ADDR_W'(r_ir[11:0]);
    assign w_redirect = (r_state == S_DECODE) &&
                        (w_is_jmp || (w_is_brz && zero_flag));

    assign w_fetch_done = (r_state == S_FETCH) && mem_ack;

    // Control-flow ops and HALT retire in DECODE; ALU ops retire in WB.
    assign w_retire = ((r_state == S_DECODE) && !w_is_alu) ||
                      (r_state == S_WB);

    // State register; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ack) w_next_state = S_DECODE;
            end
            S_DECODE: begin
                if (w_is_halt)     w_next_state = S_HALT;
                else if (w_is_alu) w_next_state = S_EXEC;
                else               w_next_state = S_FETCH;
            end
            S_EXEC: begin
                w_next_state = S_WB;
            end
            S_WB: begin
                w_next_state = S_FETCH;
            end
            S_HALT: begin
                if (start) w_next_state = S_FETCH;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the state register only, so mem_ack never
    // reaches mem_req combinationally.
    always_comb begin
        mem_req = 1'b0;
        alu_en  = 1'b0;
        wb_en   = 1'b0;
        halted  = 1'b0;
        case (r_state)
            S_FETCH: mem_req = 1'b1;
            S_EXEC:  alu_en  = 1'b1;
            S_WB:    wb_en   = 1'b1;
            S_HALT:  halted  = 1'b1;
            default: ;
        endcase
    end

    // PC and IR: capture the word and advance on a completed fetch; redirect on a taken jump/branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
            r_ir <= 16'h0000;
        end else if (w_fetch_done) begin
            r_ir <= mem_rdata;
            r_pc <= r_pc + ADDR_W'(1);
        end else if (w_redirect) begin
            r_pc <= w_target;
        end
    end

    // Retired-instruction counter; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired <= 16'h0000;
        end else if (w_retire) begin
            r_retired <= r_retired + 16'd1;
        end
    end

    assign mem_addr = r_pc;
    assign pc       = r_pc;
    assign ir       = r_ir;
    assign retired  = r_retired;
    assign state    = r_state;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed testbench for cpu_seq_ctrl.
module tb_cpu_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        zero_flag;
    logic [15:0] ir;
    logic [15:0] pc;
    logic        alu_en;
    logic        wb_en;
    logic        halted;
    logic [2:0]  state;
    logic [15:0] retired;

    // Second instance starting at 0xFFFF for the pc wrap case; it always acks with a NOP.
    logic        start2;
    logic        mem_req2;
    logic [15:0] mem_addr2;
    logic        mem_ack2;
    logic [15:0] mem_rdata2;
    logic        zero_flag2;
    logic [15:0] ir2;
    logic [15:0] pc2;
    logic        alu_en2;
    logic        wb_en2;
    logic        halted2;
    logic [2:0]  state2;
    logic [15:0] retired2;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:65535];
    int          ack_delay;
    int          wait_cnt;
    int          strobe_cnt;

    cpu_seq_ctrl #(.ADDR_W(16), .RESET_PC(16'h0000)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .zero_flag(zero_flag), .ir(ir), .pc(pc),
        .alu_en(alu_en), .wb_en(wb_en), .halted(halted), .state(state),
        .retired(retired)
    );

    cpu_seq_ctrl #(.ADDR_W(16), .RESET_PC(16'hFFFF)) u_dut_wrap (
        .clk(clk), .rst(rst), .start(start2),
        .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(mem_ack2),
        .mem_rdata(mem_rdata2), .zero_flag(zero_flag2), .ir(ir2), .pc(pc2),
        .alu_en(alu_en2), .wb_en(wb_en2), .halted(halted2), .state(state2),
        .retired(retired2)
    );

    assign mem_ack2   = 1'b1;
    assign mem_rdata2 = 16'h0000;
    assign zero_flag2 = 1'b0;

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: acks after ack_delay wait cycles, driven on negedge.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
        wait_cnt  = 0;
    end
    always @(negedge clk) begin
        if (mem_req === 1'b1) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                wait_cnt  = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'hDEAD;
                wait_cnt  = wait_cnt + 1;
            end
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 16'hDEAD;
            wait_cnt  = 0;
        end
    end

    // Counts cycles where either strobe of the main instance is high.
    initial strobe_cnt = 0;
    always @(posedge clk) begin
        if (alu_en === 1'b1 || wb_en === 1'b1) strobe_cnt <= strobe_cnt + 1;
    end

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n;
        n = 0;
        while (state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {29'd0, state}, {29'd0, s});
    endtask

    task automatic init_mem();
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
    endtask

    task automatic reset_dut();
        rst       = 1'b1;
        start     = 1'b0;
        start2    = 1'b0;
        zero_flag = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int s0;
        rst = 1'b1; start = 1'b0; start2 = 1'b0; zero_flag = 1'b0; ack_delay = 0;

        // 1: reset values, then one ALU instruction with zero-wait memory.
        init_mem();
        mem[0] = 16'h1234;
        mem[1] = 16'hF000;
        reset_dut();
        chk("rst_state",   {29'd0, state}, 32'd0);
        chk("rst_pc",      {16'd0, pc}, 32'h0000);
        chk("rst_ir",      {16'd0, ir}, 32'h0000);
        chk("rst_retired", {16'd0, retired}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_alu_en",  {31'd0, alu_en}, 32'd0);
        chk("rst_wb_en",   {31'd0, wb_en}, 32'd0);
        chk("rst_halted",  {31'd0, halted}, 32'd0);
        start = 1'b1;
        step();                                   // cycle 1: FETCH; start held high and ignored
        chk("alu_c1_state",   {29'd0, state}, 32'd1);
        chk("alu_c1_mem_req", {31'd0, mem_req}, 32'd1);
        chk("alu_c1_addr",    {16'd0, mem_addr}, 32'h0000);
        chk("alu_c1_alu_en",  {31'd0, alu_en}, 32'd0);
        step();                                   // cycle 2: DECODE
        start = 1'b0;
        chk("alu_c2_state",   {29'd0, state}, 32'd2);
        chk("alu_c2_ir",      {16'd0, ir}, 32'h1234);
        chk("alu_c2_pc",      {16'd0, pc}, 32'h0001);
        chk("alu_c2_mem_req", {31'd0, mem_req}, 32'd0);
        step();                                   // cycle 3: EXEC
        chk("alu_c3_alu_en",  {31'd0, alu_en}, 32'd1);
        chk("alu_c3_wb_en",   {31'd0, wb_en}, 32'd0);
        step();                                   // cycle 4: WB
        chk("alu_c4_wb_en",   {31'd0, wb_en}, 32'd1);
        chk("alu_c4_alu_en",  {31'd0, alu_en}, 32'd0);
        chk("alu_c4_retired", {16'd0, retired}, 32'd0);
        step();                                   // cycle 5: FETCH addr 1
        chk("alu_c5_state",   {29'd0, state}, 32'd1);
        chk("alu_c5_retired", {16'd0, retired}, 32'd1);
        chk("alu_c5_pc",      {16'd0, pc}, 32'h0001);
        wait_state(3'd5, 20, "alu_halt_reached");
        chk("alu_halt_retired", {16'd0, retired}, 32'd2);

        // 2: three wait states on the fetch of address 0.
        init_mem();
        mem[0] = 16'h1234;
        mem[1] = 16'hF000;
        ack_delay = 3;
        reset_dut();
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            chk("ws_state",   {29'd0, state}, 32'd1);
            chk("ws_mem_req", {31'd0, mem_req}, 32'd1);
            chk("ws_addr",    {16'd0, mem_addr}, 32'h0000);
            chk("ws_ir",      {16'd0, ir}, 32'h0000);
            step();
        end
        chk("ws_decode_state", {29'd0, state}, 32'd2);
        chk("ws_decode_ir",    {16'd0, ir}, 32'h1234);
        chk("ws_decode_pc",    {16'd0, pc}, 32'h0001);
        step();
        chk("ws_exec_ir", {16'd0, ir}, 32'h1234);
        step();
        chk("ws_wb_ir",   {16'd0, ir}, 32'h1234);
        wait_state(3'd5, 40, "ws_halt_reached");
        ack_delay = 0;

        // 3: JMP, then BRZ not taken, then BRZ taken.
        init_mem();
        mem[16'h0000] = 16'hC0A5;
        mem[16'h00A5] = 16'hD010;
        mem[16'h00A6] = 16'hD010;
        mem[16'h0010] = 16'hF000;
        reset_dut();
        s0 = strobe_cnt;
        pulse_start();                            // cycle 1: FETCH addr 0
        chk("jmp_c1_addr", {16'd0, mem_addr}, 32'h0000);
        step();                                   // cycle 2: DECODE JMP
        chk("jmp_c2_ir", {16'd0, ir}, 32'hC0A5);
        step();                                   // cycle 3: FETCH target
        chk("jmp_c3_state",   {29'd0, state}, 32'd1);
        chk("jmp_c3_pc",      {16'd0, pc}, 32'h00A5);
        chk("jmp_c3_addr",    {16'd0, mem_addr}, 32'h00A5);
        chk("jmp_c3_retired", {16'd0, retired}, 32'd1);
        step();                                   // cycle 4: DECODE BRZ, zero_flag=0
        chk("brz_nt_ir", {16'd0, ir}, 32'hD010);
        step();                                   // cycle 5: FETCH
        chk("brz_nt_pc",      {16'd0, pc}, 32'h00A6);
        chk("brz_nt_retired", {16'd0, retired}, 32'd2);
        zero_flag = 1'b1;
        step();                                   // cycle 6: DECODE BRZ, zero_flag=1
        chk("brz_t_decode_pc", {16'd0, pc}, 32'h00A7);
        step();                                   // cycle 7: FETCH target
        zero_flag = 1'b0;
        chk("brz_t_pc",      {16'd0, pc}, 32'h0010);
        chk("brz_t_addr",    {16'd0, mem_addr}, 32'h0010);
        chk("brz_t_retired", {16'd0, retired}, 32'd3);
        wait_state(3'd5, 20, "brz_halt_reached");
        chk("jmp_no_strobes", strobe_cnt - s0, 32'd0);

        // 4: HALT at address 5, idle in HALT, resume at address 6.
        init_mem();
        mem[5] = 16'hF000;
        mem[6] = 16'hF000;
        reset_dut();
        pulse_start();
        wait_state(3'd5, 40, "halt_reached");
        chk("halt_halted",  {31'd0, halted}, 32'd1);
        chk("halt_pc",      {16'd0, pc}, 32'h0006);
        chk("halt_retired", {16'd0, retired}, 32'd6);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("halt_idle_mem_req", {31'd0, mem_req}, 32'd0);
            chk("halt_idle_halted",  {31'd0, halted}, 32'd1);
            chk("halt_idle_pc",      {16'd0, pc}, 32'h0006);
        end
        chk("halt_idle_retired", {16'd0, retired}, 32'd6);
        pulse_start();
        chk("resume_state",   {29'd0, state}, 32'd1);
        chk("resume_addr",    {16'd0, mem_addr}, 32'h0006);
        chk("resume_halted",  {31'd0, halted}, 32'd0);
        chk("resume_mem_req", {31'd0, mem_req}, 32'd1);
        step();
        chk("resume_ir", {16'd0, ir}, 32'hF000);
        chk("resume_pc", {16'd0, pc}, 32'h0007);
        step();
        chk("resume_halt_state",   {29'd0, state}, 32'd5);
        chk("resume_halt_retired", {16'd0, retired}, 32'd7);

        // 5: pc wrap from 0xFFFF on the second instance.
        reset_dut();
        chk("wrap_rst_pc", {16'd0, pc2}, 32'hFFFF);
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        chk("wrap_c1_addr",    {16'd0, mem_addr2}, 32'hFFFF);
        chk("wrap_c1_mem_req", {31'd0, mem_req2}, 32'd1);
        step();
        chk("wrap_c2_state", {29'd0, state2}, 32'd2);
        chk("wrap_c2_pc",    {16'd0, pc2}, 32'h0000);
        step();
        chk("wrap_c3_addr",    {16'd0, mem_addr2}, 32'h0000);
        chk("wrap_c3_retired", {16'd0, retired2}, 32'd1);

        // 6: reset during FETCH while mem_ack is high.
        init_mem();
        mem[0] = 16'h1234;
        reset_dut();
        pulse_start();
        chk("rstf_pre_state", {29'd0, state}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstf_state",   {29'd0, state}, 32'd0);
        chk("rstf_pc",      {16'd0, pc}, 32'h0000);
        chk("rstf_ir",      {16'd0, ir}, 32'h0000);
        chk("rstf_retired", {16'd0, retired}, 32'd0);
        chk("rstf_mem_req", {31'd0, mem_req}, 32'd0);
        step();
        chk("rstf_stay_idle", {29'd0, state}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
